// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter unit.
package pc_pkg;

    localparam int unsigned PC_INC = 4;

    // Which source the next PC is taken from.
    typedef enum logic [2:0] {
        HOLD,
        FLUSH,
        BRANCH,
        RET,
        SEQ
    } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and a saturating count.
// Pushing when full overwrites the oldest entry; push+pop replaces the top in place.
module pc_ras
    import pc_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] wdata_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [PTR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] mem [RAS_DEPTH];

    logic              replace;
    logic              grow;
    logic              shrink;
    logic [PTR_W-1:0]  wr_idx;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign top_o   = mem[ptr_q];

    // A combined push+pop on an empty stack degrades to a plain push.
    always_comb begin
        replace = push_i && pop_i && !empty_o;
        grow    = push_i && !replace;
        shrink  = pop_i && !push_i && !empty_o;
        wr_idx  = replace ? ptr_q : ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (grow) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (!full_o) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (shrink) begin
            ptr_q <= ptr_q - PTR_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Storage is left unreset; only pointer and count define validity.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_idx] <= wdata_i;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC priority select, PC register and +4 adder.
// Optional return-address stack is built when PC_UNIT_RAS_EN is defined.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_pc_i,
    input  logic              call_i,
    input  logic              ret_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              misalign_o,
    output logic              ras_empty_o,
    output logic              ras_full_o
);

    logic [ADDR_W-1:0] pc_q;
    logic              valid_q;
    logic [ADDR_W-1:0] pc_plus;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] ras_top;
    logic              ret_hit;
    logic              seq_path;
    pc_src_e           src;

    assign pc_plus    = pc_q + ADDR_W'(PC_INC);
    assign pc_o       = pc_q;
    assign pc_valid_o = valid_q;
    assign misalign_o = |pc_q[1:0];
    assign seq_path   = start_i && !flush_i && !branch_i && !stall_i;

`ifdef PC_UNIT_RAS_EN
    logic ras_empty;
    logic ras_full;

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (seq_path && call_i),
        .pop_i   (seq_path && ret_i),
        .wdata_i (pc_plus),
        .top_o   (ras_top),
        .empty_o (ras_empty),
        .full_o  (ras_full)
    );

    assign ret_hit     = ret_i && !ras_empty;
    assign ras_empty_o = ras_empty;
    assign ras_full_o  = ras_full;
`else
    logic unused_ras;

    assign unused_ras  = &{1'b0, call_i, ret_i};
    assign ras_top     = '0;
    assign ret_hit     = 1'b0;
    assign ras_empty_o = 1'b1;
    assign ras_full_o  = 1'b0;
`endif

    always_comb begin
        src = SEQ;
        if (!start_i) begin
            src = HOLD;
        end else if (flush_i) begin
            src = FLUSH;
        end else if (branch_i) begin
            src = BRANCH;
        end else if (stall_i) begin
            src = HOLD;
        end else if (ret_hit) begin
            src = RET;
        end
    end

    always_comb begin
        pc_next = pc_plus;
        case (src)
            HOLD:    pc_next = pc_q;
            FLUSH:   pc_next = flush_pc_i;
            BRANCH:  pc_next = branch_pc_i;
            RET:     pc_next = ras_top;
            default: pc_next = pc_plus;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_next;
            valid_q <= start_i;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit; RAS scenarios run when PC_UNIT_RAS_EN is defined.
module tb_pc_unit;

  localparam int AW = 32;
  localparam int EW = AW + 4;  // {valid, misalign, empty, full, pc}

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i, stall_i, flush_i, branch_i, call_i, ret_i;
  logic [AW-1:0] flush_pc_i, branch_pc_i;
  logic [AW-1:0] pc_o;
  logic          pc_valid_o, misalign_o, ras_empty_o, ras_full_o;

  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  pc_unit #(.ADDR_W(AW), .RESET_VEC('0), .RAS_DEPTH(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .flush_pc_i  (flush_pc_i),
    .branch_i    (branch_i),
    .branch_pc_i (branch_pc_i),
    .call_i      (call_i),
    .ret_i       (ret_i),
    .pc_o        (pc_o),
    .pc_valid_o  (pc_valid_o),
    .misalign_o  (misalign_o),
    .ras_empty_o (ras_empty_o),
    .ras_full_o  (ras_full_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // monitor: every registered update is compared against the scoreboard head
  always @(posedge clk_i) begin
    logic [EW-1:0] exp;
    logic [EW-1:0] act;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {pc_valid_o, misalign_o, ras_empty_o, ras_full_o, pc_o};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL step%0d: got v=%b m=%b e=%b f=%b pc=%h, want v=%b m=%b e=%b f=%b pc=%h",
                 checks, act[EW-1], act[EW-2], act[EW-3], act[EW-4], act[AW-1:0],
                 exp[EW-1], exp[EW-2], exp[EW-3], exp[EW-4], exp[AW-1:0]);
      end
    end
  end

  task automatic check_now(input string name, input logic [EW-1:0] exp);
    logic [EW-1:0] act;
    act = {pc_valid_o, misalign_o, ras_empty_o, ras_full_o, pc_o};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [AW-1:0] pc, input logic v,
                                       input logic e, input logic f);
    logic [AW-1:0] p;
    p = pc;
    return {v, |p[1:0], e, f, p};
  endfunction

  // driver: apply controls on negedge, post expected post-edge state, take the edge
  task automatic step(input logic st, input logic stl, input logic fl, input logic [AW-1:0] fpc,
                      input logic br, input logic [AW-1:0] bpc, input logic ca, input logic re,
                      input logic [AW-1:0] epc, input logic ev, input logic ee, input logic ef);
    @(negedge clk_i);
    start_i = st; stall_i = stl; flush_i = fl; flush_pc_i = fpc;
    branch_i = br; branch_pc_i = bpc; call_i = ca; ret_i = re;
    exp_q.push_back(mk(epc, ev, ee, ef));
    @(posedge clk_i);
  endtask

  task automatic seq(input logic ca, input logic re, input logic [AW-1:0] epc,
                     input logic ee, input logic ef);
    step(1, 0, 0, '0, 0, '0, ca, re, epc, 1, ee, ef);
  endtask

  task automatic jump(input logic [AW-1:0] tgt, input logic ee, input logic ef);
    step(1, 0, 0, '0, 1, tgt, 0, 0, tgt, 1, ee, ef);
  endtask

  initial begin
    rst_i = 1'b0;
    start_i = 0; stall_i = 0; flush_i = 0; branch_i = 0; call_i = 0; ret_i = 0;
    flush_pc_i = '0; branch_pc_i = '0;
    #12;
    check_now("reset", mk(32'h0, 0, 1, 0));
    rst_i = 1'b1;

    // sequential fetch after reset
    seq(0, 0, 32'h4, 1, 0);
    seq(0, 0, 32'h8, 1, 0);
    seq(0, 0, 32'hC, 1, 0);
    // start low holds, valid drops
    step(0, 0, 0, '0, 1, 32'h40, 0, 0, 32'hC, 0, 1, 0);
    // branch beats stall; stall alone holds; flush beats branch
    step(1, 1, 0, '0, 1, 32'h100, 0, 0, 32'h100, 1, 1, 0);
    step(1, 1, 0, '0, 0, '0, 0, 0, 32'h100, 1, 1, 0);
    step(1, 0, 1, 32'h200, 1, 32'h300, 0, 0, 32'h200, 1, 1, 0);
    // misaligned target loaded unmodified
    jump(32'h102, 1, 0);
    seq(0, 0, 32'h106, 1, 0);
    // adder wraps
    jump(32'hFFFF_FFFC, 1, 0);
    seq(0, 0, 32'h0, 1, 0);
    // return on empty stack (or without RAS) falls through to +4
    seq(0, 1, 32'h4, 1, 0);

`ifdef PC_UNIT_RAS_EN
    // five calls into a depth-4 stack: oldest (0x14) is overwritten
    jump(32'h10, 1, 0); seq(1, 0, 32'h14, 0, 0);
    jump(32'h20, 0, 0); seq(1, 0, 32'h24, 0, 0);
    jump(32'h30, 0, 0); seq(1, 0, 32'h34, 0, 0);
    jump(32'h40, 0, 0); seq(1, 0, 32'h44, 0, 1);
    jump(32'h50, 0, 1); seq(1, 0, 32'h54, 0, 1);
    seq(0, 1, 32'h54, 0, 0);
    seq(0, 1, 32'h44, 0, 0);
    seq(0, 1, 32'h34, 0, 0);
    seq(0, 1, 32'h24, 1, 0);
    seq(0, 1, 32'h28, 1, 0);
    // stalled call must not push
    step(1, 1, 0, '0, 0, '0, 1, 0, 32'h28, 1, 1, 0);
    // call+ret swaps the top: top 0x200 at pc 0x80
    jump(32'h1FC, 1, 0); seq(1, 0, 32'h200, 0, 0);
    jump(32'h80, 0, 0);
    seq(1, 1, 32'h200, 0, 0);
    seq(0, 1, 32'h84, 1, 0);
    // call+ret on empty is a push only
    seq(1, 1, 32'h88, 0, 0);
    seq(0, 1, 32'h88, 1, 0);
    seq(1, 0, 32'h8C, 0, 0);
`endif

    // async reset mid-run, with a pending flush that must be lost
    @(negedge clk_i);
    flush_i = 1; flush_pc_i = 32'h500; start_i = 1;
    #2 rst_i = 1'b0;
    #1 check_now("async_reset", mk(32'h0, 0, 1, 0));
    @(posedge clk_i); #1;
    check_now("reset_hold", mk(32'h0, 0, 1, 0));
    rst_i = 1'b1;
    flush_i = 0;
    seq(0, 1, 32'h4, 1, 0);

    repeat (2) @(posedge clk_i);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
